// File: rtl/usart_pkg.sv
// Shared types and constants for the mcu8bit USART receive path.
package usart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_RSVD = 2'b01;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  localparam int unsigned RX_WORD_W  = 11;
  localparam int unsigned RX_UPE_BIT = 10;
  localparam int unsigned RX_FE_BIT  = 9;

  // Number of data bits for a character-size code; reserved codes act as 8.
  function automatic logic [3:0] char_bits(input logic [2:0] ucsz);
    case (ucsz)
      UCSZ_5:  char_bits = 4'd5;
      UCSZ_6:  char_bits = 4'd6;
      UCSZ_7:  char_bits = 4'd7;
      UCSZ_8:  char_bits = 4'd8;
      UCSZ_9:  char_bits = 4'd9;
      default: char_bits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// rxd synchroniser, oversample slot counter and 3-sample majority vote.
module usart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic cp2,
  input  logic ireset,
  input  logic rxd,
  input  logic baud_tick,
  input  logic u2x,
  input  logic active,
  input  logic start,
  output logic rxd_sync,
  output logic vote_valid,
  output logic vote_bit,
  output logic slot_end
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0] slot_q, slot_d;
  logic [1:0] samp_q, samp_d;
  logic [3:0] slot_cur;
  logic [3:0] slot_first, slot_mid, slot_last, slot_n;

  assign rxd_sync = sync_q[SYNC_STAGES-1];

  // Slot of the current tick. With N=16 the 4-bit counter holds slot 16 as 0,
  // so plain wrap-around gives 16 -> 1; with N=8 it is wrapped explicitly.
  always_comb begin
    slot_n     = u2x ? 4'd8 : 4'd0;
    slot_first = u2x ? 4'd4 : 4'd8;
    slot_mid   = u2x ? 4'd5 : 4'd9;
    slot_last  = u2x ? 4'd6 : 4'd10;
    if (u2x && slot_q == 4'd8) slot_cur = 4'd1;
    else                       slot_cur = slot_q + 4'd1;
    vote_valid = active && baud_tick && (slot_cur == slot_last);
    slot_end   = active && baud_tick && (slot_cur == slot_n);
    vote_bit   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync) |
                 (samp_q[1] & rxd_sync);
  end

  // Next-state for synchroniser, slot counter and captured samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    slot_d = slot_q;
    samp_d = samp_q;
    if (start) begin
      slot_d = 4'd1;
      samp_d = '1;
    end else if (!active) begin
      slot_d = '0;
      samp_d = '1;
    end else if (baud_tick) begin
      slot_d = slot_cur;
      if (slot_cur == slot_first) samp_d[0] = rxd_sync;
      if (slot_cur == slot_mid)   samp_d[1] = rxd_sync;
    end
  end

  // Sampler state registers.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync_q <= '1;
      slot_q <= '0;
      samp_q <= '1;
    end else begin
      sync_q <= sync_d;
      slot_q <= slot_d;
      samp_q <= samp_d;
    end
  end

endmodule

// File: rtl/usart_rx_core.sv
// USART receive FSM: deserialise, check parity/stop, write status-tagged words.
module usart_rx_core
  import usart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 cp2,
  input  logic                 ireset,
  input  logic                 rxd,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 u2x,
  input  logic [2:0]           ucsz,
  input  logic [1:0]           upm,
  input  logic                 fifo_full,
  output logic [RX_WORD_W-1:0] fifo_din,
  output logic                 fifo_we,
  output logic                 dor,
  output logic                 rx_busy
);

  rx_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] data_q, data_d;
  logic       upe_q, upe_d;
  logic [2:0] ucsz_q, ucsz_d;
  logic [1:0] upm_q, upm_d;
  logic       u2x_q, u2x_d;
  logic [RX_WORD_W-1:0] fifo_din_q, fifo_din_d;
  logic       fifo_we_q, fifo_we_d;
  logic       dor_q, dor_d;

  logic rxd_sync, vote_valid, vote_bit, slot_end;
  logic start, active, exp_par, fe;
  logic [3:0] nbits;

  assign active   = (state_q != RX_IDLE);
  assign rx_busy  = active;
  assign fifo_din = fifo_din_q;
  assign fifo_we  = fifo_we_q;
  assign dor      = dor_q;

  usart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .cp2       (cp2),
    .ireset    (ireset),
    .rxd       (rxd),
    .baud_tick (baud_tick),
    .u2x       (u2x_q),
    .active    (active),
    .start     (start),
    .rxd_sync  (rxd_sync),
    .vote_valid(vote_valid),
    .vote_bit  (vote_bit),
    .slot_end  (slot_end)
  );

  // Next-state, deserialisation, parity/stop checking and FIFO write.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    upe_d      = upe_q;
    ucsz_d     = ucsz_q;
    upm_d      = upm_q;
    u2x_d      = u2x_q;
    fifo_din_d = fifo_din_q;
    fifo_we_d  = 1'b0;
    dor_d      = dor_q;
    start      = 1'b0;
    nbits      = char_bits(ucsz_q);
    exp_par    = (upm_q == UPM_ODD) ? ~(^data_q) : (^data_q);
    fe         = ~vote_bit;

    if (!rx_en) begin
      state_d   = RX_IDLE;
      bit_cnt_d = '0;
      dor_d     = 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (baud_tick && !rxd_sync) begin
            state_d   = RX_START;
            start     = 1'b1;
            bit_cnt_d = '0;
            data_d    = '0;
            upe_d     = 1'b0;
            ucsz_d    = ucsz;
            upm_d     = upm;
            u2x_d     = u2x;
          end
        end
        RX_START: begin
          if (vote_valid && vote_bit) begin
            state_d = RX_IDLE;
          end else if (slot_end) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          if (vote_valid) begin
            data_d[bit_cnt_q] = vote_bit;
            bit_cnt_d         = bit_cnt_q + 4'd1;
          end
          if (slot_end && bit_cnt_q == nbits) begin
            state_d = upm_q[1] ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (vote_valid) upe_d = (vote_bit != exp_par);
          if (slot_end)   state_d = RX_STOP;
        end
        RX_STOP: begin
          if (vote_valid) begin
            state_d = RX_IDLE;
            if (!fifo_full) begin
              fifo_we_d  = 1'b1;
              fifo_din_d = {upe_q, fe, data_q};
              dor_d      = 1'b0;
            end else begin
              dor_d = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Receiver state registers.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      upe_q      <= 1'b0;
      ucsz_q     <= UCSZ_8;
      upm_q      <= UPM_NONE;
      u2x_q      <= 1'b0;
      fifo_din_q <= '0;
      fifo_we_q  <= 1'b0;
      dor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      upe_q      <= upe_d;
      ucsz_q     <= ucsz_d;
      upm_q      <= upm_d;
      u2x_q      <= u2x_d;
      fifo_din_q <= fifo_din_d;
      fifo_we_q  <= fifo_we_d;
      dor_q      <= dor_d;
    end
  end

endmodule

// File: tb/tb_usart_rx_core.sv
// Directed bench for usart_rx_core with a scoreboard of expected FIFO words.
module tb_usart_rx_core;

  logic        cp2 = 1'b0;
  logic        ireset;
  logic        rxd;
  logic        rx_en;
  logic        baud_tick;
  logic        u2x;
  logic [2:0]  ucsz;
  logic [1:0]  upm;
  logic        fifo_full;
  logic [10:0] fifo_din;
  logic        fifo_we;
  logic        dor;
  logic        rx_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned nwr   = 0;
  logic [10:0] sb[$];

  usart_rx_core #(.SYNC_STAGES(2)) dut (
    .cp2      (cp2),
    .ireset   (ireset),
    .rxd      (rxd),
    .rx_en    (rx_en),
    .baud_tick(baud_tick),
    .u2x      (u2x),
    .ucsz     (ucsz),
    .upm      (upm),
    .fifo_full(fifo_full),
    .fifo_din (fifo_din),
    .fifo_we  (fifo_we),
    .dor      (dor),
    .rx_busy  (rx_busy)
  );

  always #5 cp2 = ~cp2;

  // Oversample tick: one cycle in four.
  initial begin
    int unsigned cnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge cp2);
      baud_tick = (cnt == 3);
      cnt = (cnt + 1) % 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected word.
  always @(negedge cp2) begin
    if (fifo_we === 1'b1) begin
      nwr++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=0x%0h expected=none", fifo_din);
      end
      if (sb.size() != 0) check("fifo_din", {21'd0, fifo_din}, {21'd0, sb.pop_front()});
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_slots(input int unsigned n);
    repeat (n * 4) @(negedge cp2);
  endtask

  function automatic int unsigned nslots();
    return u2x ? 8 : 16;
  endfunction

  function automatic logic ref_parity(input logic [8:0] d, input int unsigned nbits, input logic odd);
    int unsigned ones = 0;
    for (int i = 0; i < 9; i++) if (i < nbits && d[i]) ones++;
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic [10:0] ref_word(input logic [8:0] d, input int unsigned nbits,
                                           input logic has_par, input logic par_sent,
                                           input logic odd, input logic stop);
    logic [8:0] m = '0;
    logic upe;
    for (int i = 0; i < 9; i++) if (i < nbits) m[i] = d[i];
    upe = has_par && (par_sent != ref_parity(d, nbits, odd));
    return {upe, ~stop, m};
  endfunction

  task automatic send_frame(input logic [8:0] d, input int unsigned nbits,
                            input logic has_par, input logic par_bit, input logic stop);
    int unsigned n = nslots();
    rxd = 1'b0;
    wait_slots(n);
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        rxd = d[i];
        wait_slots(n);
      end
    end
    if (has_par) begin
      rxd = par_bit;
      wait_slots(n);
    end
    rxd = stop;
    wait_slots(n);
    rxd = 1'b1;
    wait_slots(2 * n);
  endtask

  task automatic send_partial(input logic [8:0] d, input int unsigned nbits);
    int unsigned n = nslots();
    rxd = 1'b0;
    wait_slots(n);
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        rxd = d[i];
        wait_slots(n);
      end
    end
  endtask

  initial begin
    logic p;
    int unsigned w;

    ireset = 1'b0; rxd = 1'b1; rx_en = 1'b1; u2x = 1'b0;
    ucsz = 3'b011; upm = 2'b00; fifo_full = 1'b0;
    repeat (4) @(negedge cp2);
    check("rst_fifo_din", {21'd0, fifo_din}, 32'h0);
    check("rst_fifo_we",  {31'd0, fifo_we}, 32'h0);
    check("rst_dor",      {31'd0, dor}, 32'h0);
    check("rst_rx_busy",  {31'd0, rx_busy}, 32'h0);
    ireset = 1'b1;
    wait_slots(4);

    // 8N1, N=16
    sb.push_back(ref_word(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
    check("dor_after_a5", {31'd0, dor}, 32'h0);

    // 9E1, N=8: good then corrupted parity
    u2x = 1'b1; ucsz = 3'b111; upm = 2'b10;
    p = ref_parity(9'h1C3, 9, 1'b0);
    sb.push_back(ref_word(9'h1C3, 9, 1'b1, p, 1'b0, 1'b1));
    send_frame(9'h1C3, 9, 1'b1, p, 1'b1);
    sb.push_back(ref_word(9'h1C3, 9, 1'b1, ~p, 1'b0, 1'b1));
    send_frame(9'h1C3, 9, 1'b1, ~p, 1'b1);

    // 7N1 with framing error, then a clean frame
    u2x = 1'b0; ucsz = 3'b010; upm = 2'b00;
    sb.push_back(ref_word(9'h035, 7, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(9'h035, 7, 1'b0, 1'b0, 1'b0);
    sb.push_back(ref_word(9'h012, 7, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(9'h012, 7, 1'b0, 1'b0, 1'b1);

    // Short low glitch is rejected as a false start
    ucsz = 3'b011;
    w = nwr;
    rxd = 1'b0;
    wait_slots(4);
    check("glitch_busy", {31'd0, rx_busy}, 32'h1);
    rxd = 1'b1;
    wait_slots(16);
    check("glitch_idle", {31'd0, rx_busy}, 32'h0);
    check("glitch_nowr", nwr, w);

    // Overrun when FIFO full, cleared by next successful write
    fifo_full = 1'b1;
    w = nwr;
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b1);
    check("dor_set", {31'd0, dor}, 32'h1);
    check("dor_nowr", nwr, w);
    fifo_full = 1'b0;
    sb.push_back(ref_word(9'h066, 8, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(9'h066, 8, 1'b0, 1'b0, 1'b1);
    check("dor_clr_wr", {31'd0, dor}, 32'h0);

    // rx_en abort mid-DATA clears overrun and drops the frame
    fifo_full = 1'b1;
    send_frame(9'h077, 8, 1'b0, 1'b0, 1'b1);
    check("dor_set2", {31'd0, dor}, 32'h1);
    fifo_full = 1'b0;
    w = nwr;
    send_partial(9'h005, 3);
    check("abort_busy", {31'd0, rx_busy}, 32'h1);
    rx_en = 1'b0;
    repeat (2) @(negedge cp2);
    check("abort_idle", {31'd0, rx_busy}, 32'h0);
    check("abort_dor", {31'd0, dor}, 32'h0);
    rxd = 1'b1;
    wait_slots(32);
    rx_en = 1'b1;
    wait_slots(16);
    check("abort_nowr", nwr, w);

    // Reset mid-frame
    fifo_full = 1'b1;
    send_frame(9'h088, 8, 1'b0, 1'b0, 1'b1);
    fifo_full = 1'b0;
    w = nwr;
    send_partial(9'h003, 3);
    ireset = 1'b0;
    #1;
    check("mrst_busy", {31'd0, rx_busy}, 32'h0);
    check("mrst_we",   {31'd0, fifo_we}, 32'h0);
    check("mrst_din",  {21'd0, fifo_din}, 32'h0);
    check("mrst_dor",  {31'd0, dor}, 32'h0);
    rxd = 1'b1;
    repeat (4) @(negedge cp2);
    ireset = 1'b1;
    wait_slots(32);
    check("mrst_nowr", nwr, w);
    sb.push_back(ref_word(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1));
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1);
    check("final_dor", {31'd0, dor}, 32'h0);

    wait_slots(16);
    check("sb_empty", sb.size(), 32'd0);
    check("write_count", nwr, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
